// File: rtl/atan_req_arbiter_if.sv
// Request/result bundle between the vector front end, the arbiter and the
// heading consumer. The arbiter connects through the slave modport.
interface atan_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*10-1:0] req_x;
  logic [NUM_REQ*9-1:0]  req_y;
  logic                  res_valid;
  logic                  res_ready;
  logic [IDW-1:0]        res_id;
  logic [8:0]            res_angle;

  modport master (
    output req_valid, req_x, req_y, res_ready,
    input  req_ready, res_valid, res_id, res_angle
  );

  modport slave (
    input  req_valid, req_x, req_y, res_ready,
    output req_ready, res_valid, res_id, res_angle
  );
endinterface

// File: rtl/atan_req_arbiter.sv
// Round-robin sharing of one combinational atan LUT between NUM_REQ vector
// sources; each result is registered and handed to one consumer with its id.
module atan_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  atan_req_arbiter_if.slave   bus,
  output logic signed [9:0]   lut_x,
  output logic signed [8:0]   lut_y,
  input  logic [8:0]          lut_angle,
  output logic                busy,
  output logic [CNT_W-1:0]    done_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDW-1:0]      r_rr_ptr;
  logic [IDW-1:0]      r_cur_id;
  logic [IDW-1:0]      r_res_id;
  logic [IDW-1:0]      w_winner;
  logic                w_found;
  logic [NUM_REQ-1:0]  w_ready;
  logic                w_accept;
  logic                w_handshake;
  logic signed [9:0]   r_op_x;
  logic signed [8:0]   r_op_y;
  logic                r_res_valid;
  logic [8:0]          r_res_angle;
  logic [CNT_W-1:0]    r_done_count;

  // The LUT may report a full turn as 360; fold it back into 0..359.
  function automatic logic [8:0] norm_angle(input logic [8:0] a);
    return (a >= 9'd360) ? (a - 9'd360) : a;
  endfunction

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    logic [IDW-1:0] idx;
    idx      = '0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = r_rr_ptr + IDW'(k);
      if (!w_found && bus.req_valid[idx]) begin
        w_found  = 1'b1;
        w_winner = idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    w_accept    = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_ready[w_winner] = 1'b1;
          w_accept          = 1'b1;
          w_state_nxt       = S_LOOKUP;
        end
      end
      S_LOOKUP: w_state_nxt = S_RESULT;
      S_RESULT: begin
        if (bus.res_ready) begin
          w_handshake = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_cur_id     <= '0;
      r_op_x       <= '0;
      r_op_y       <= '0;
      r_res_valid  <= 1'b0;
      r_res_id     <= '0;
      r_res_angle  <= '0;
      r_done_count <= '0;
    end else begin
      if (w_accept) begin
        r_op_x   <= signed'(bus.req_x[10*w_winner +: 10]);
        r_op_y   <= signed'(bus.req_y[9*w_winner +: 9]);
        r_cur_id <= w_winner;
      end
      if (r_state == S_LOOKUP) begin
        r_res_angle <= norm_angle(lut_angle);
        r_res_id    <= r_cur_id;
        r_res_valid <= 1'b1;
      end
      if (w_handshake) begin
        r_res_valid  <= 1'b0;
        r_rr_ptr     <= r_cur_id + IDW'(1);
        r_done_count <= r_done_count + CNT_W'(1);
      end
    end
  end

  // Operands stay registered outside LOOKUP so the LUT input never glitches.
  assign lut_x         = r_op_x;
  assign lut_y         = r_op_y;
  assign bus.req_ready = rst ? '0 : w_ready;
  assign bus.res_valid = r_res_valid;
  assign bus.res_id    = r_res_id;
  assign bus.res_angle = r_res_angle;
  assign busy          = (r_state != S_IDLE);
  assign done_count    = r_done_count;

endmodule

// File: tb/tb_atan_req_arbiter.sv
// Bench for atan_req_arbiter: behavioural atan LUT with override, scoreboard of
// expected (id, angle) pushed at grant and popped at the result handshake.
module tb_atan_req_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;
  localparam int CNT_W   = 16;

  typedef struct {
    int id;
    int angle;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [9:0] lut_x;
  logic signed [8:0] lut_y;
  logic [8:0]        lut_angle;
  logic              busy;
  logic [CNT_W-1:0]  done_count;

  bit ovr_en  = 1'b0;
  int ovr_val = 0;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  int   grant_q[$];
  int   last_id    = -1;
  int   last_angle = -1;

  int                mon_g;
  logic signed [9:0] mon_sx;
  logic signed [8:0] mon_sy;
  exp_t              mon_e;

  atan_req_arbiter_if #(.NUM_REQ(NUM_REQ), .IDW(IDW)) bus ();

  atan_req_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .lut_x      (lut_x),
    .lut_y      (lut_y),
    .lut_angle  (lut_angle),
    .busy       (busy),
    .done_count (done_count)
  );

  always #5 clk = ~clk;

  function automatic int lut_model(input int x, input int y, input bit en, input int v);
    real r;
    if (en) return v;
    r = $atan2(real'(y), real'(x)) * 180.0 / 3.14159265358979;
    if (r < 0.0) r = r + 360.0;
    return int'(r);
  endfunction

  function automatic int norm(input int a);
    return (a >= 360) ? a - 360 : a;
  endfunction

  assign lut_angle = 9'(lut_model(int'(lut_x), int'(lut_y), ovr_en, ovr_val));

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Scoreboard: grants seen before the accepting edge, results before the handshake edge.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if ((bus.req_valid & bus.req_ready) != '0) begin
        mon_g = 0;
        for (int k = 0; k < NUM_REQ; k++)
          if (bus.req_ready[k]) mon_g = k;
        mon_sx = bus.req_x[10*mon_g +: 10];
        mon_sy = bus.req_y[9*mon_g +: 9];
        sb_q.push_back('{mon_g, norm(lut_model(int'(mon_sx), int'(mon_sy), ovr_en, ovr_val))});
        grant_q.push_back(mon_g);
      end
      if (bus.res_valid && bus.res_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected_result", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check_eq("sb_res_id", 32'(bus.res_id), 32'(mon_e.id));
          check_eq("sb_res_angle", 32'(bus.res_angle), 32'(mon_e.angle));
        end
        last_id    = int'(bus.res_id);
        last_angle = int'(bus.res_angle);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int i, input bit v, input int x, input int y);
    bus.req_valid[i]        = v;
    bus.req_x[10*i +: 10]   = 10'(x);
    bus.req_y[9*i +: 9]     = 9'(y);
  endtask

  task automatic wait_grant(input int i);
    bit ok;
    ok = 1'b0;
    #1;
    for (int c = 0; c < 20 && !ok; c++) begin
      if (bus.req_ready[i]) ok = 1'b1;
      else tick(1);
    end
    if (!ok) check_eq("grant_timeout", 32'd0, 32'd1);
    tick(1);
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < 30) begin
      tick(1);
      c++;
    end
    if (busy) check_eq("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_req(input int i, input int x, input int y);
    set_req(i, 1'b1, x, y);
    wait_grant(i);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int cap_id;
    int cap_ang;
    int cap_done;
    int c;

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.res_ready = 1'b0;
    tick(2);
    check_eq("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done_count), 32'd0);
    check_eq("rst_lut_x", 32'(lut_x), 32'd0);
    check_eq("rst_res_angle", 32'(bus.res_angle), 32'd0);
    bus.req_valid = 4'b1111;
    #1;
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = '0;
    rst = 1'b0;
    tick(1);

    // Single request, step by step.
    set_req(0, 1'b1, 100, 0);
    bus.res_ready = 1'b1;
    #1;
    check_eq("p1_req_ready", 32'(bus.req_ready), 32'b0001);
    tick(1);
    bus.req_valid[0] = 1'b0;
    check_eq("p1_busy_lookup", 32'(busy), 32'd1);
    check_eq("p1_lut_x", 32'(lut_x), 32'd100);
    check_eq("p1_valid_lookup", 32'(bus.res_valid), 32'd0);
    tick(1);
    check_eq("p1_res_valid", 32'(bus.res_valid), 32'd1);
    check_eq("p1_res_id", 32'(bus.res_id), 32'd0);
    check_eq("p1_res_angle", 32'(bus.res_angle), 32'd0);
    tick(1);
    check_eq("p1_done", 32'(done_count), 32'd1);
    check_eq("p1_valid_after", 32'(bus.res_valid), 32'd0);
    check_eq("p1_lut_x_held", 32'(lut_x), 32'd100);

    // Quadrant pass-through.
    do_req(2, -100, 0);
    check_eq("q_id_180", 32'(last_id), 32'd2);
    check_eq("q_angle_180", 32'(last_angle), 32'd180);
    do_req(2, 0, -100);
    check_eq("q_id_270", 32'(last_id), 32'd2);
    check_eq("q_angle_270", 32'(last_angle), 32'd270);

    // LUT reporting 360 folds to 0; 359 passes.
    ovr_en  = 1'b1;
    ovr_val = 360;
    do_req(1, 5, 5);
    check_eq("norm_360", 32'(last_angle), 32'd0);
    ovr_val = 359;
    do_req(1, 5, 5);
    check_eq("norm_359", 32'(last_angle), 32'd359);
    ovr_en = 1'b0;
    check_eq("done_after_5", 32'(done_count), 32'd5);

    // Round-robin with everyone requesting from reset.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    base = grant_q.size();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 20 * (i + 1), 15 * i);
    c = 0;
    while (grant_q.size() - base < 6 && c < 60) begin
      tick(1);
      c++;
    end
    bus.req_valid = '0;
    if (grant_q.size() - base < 6) begin
      check_eq("rr_timeout", 32'(grant_q.size() - base), 32'd6);
    end else begin
      for (int k = 0; k < 6; k++)
        check_eq($sformatf("rr_grant%0d", k), 32'(grant_q[base + k]), 32'(k % NUM_REQ));
    end
    wait_idle();
    check_eq("rr_done", 32'(done_count), 32'd6);

    // Backpressure while other requesters are pending.
    bus.res_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, -50, 30 + i);
    c = 0;
    while (!bus.res_valid && c < 20) begin
      tick(1);
      c++;
    end
    check_eq("bp_res_valid_seen", 32'(bus.res_valid), 32'd1);
    check_eq("bp_res_id", 32'(bus.res_id), 32'd2);
    cap_id   = int'(bus.res_id);
    cap_ang  = int'(bus.res_angle);
    cap_done = int'(done_count);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check_eq("bp_hold_valid", 32'(bus.res_valid), 32'd1);
      check_eq("bp_hold_id", 32'(bus.res_id), 32'(cap_id));
      check_eq("bp_hold_angle", 32'(bus.res_angle), 32'(cap_ang));
      check_eq("bp_req_ready", 32'(bus.req_ready), 32'd0);
      check_eq("bp_done", 32'(done_count), 32'(cap_done));
    end
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    tick(1);
    check_eq("bp_done_inc", 32'(done_count), 32'(cap_done + 1));
    wait_idle();

    // Reset while in LOOKUP discards the request and the pointer.
    set_req(3, 1'b1, 0, 100);
    wait_grant(3);
    check_eq("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_eq("mid_res_valid", 32'(bus.res_valid), 32'd0);
    check_eq("mid_busy_after", 32'(busy), 32'd0);
    check_eq("mid_done", 32'(done_count), 32'd0);
    bus.req_valid = 4'b1110;
    bus.req_valid[0] = 1'b1;
    #1;
    check_eq("mid_rr_ptr0", 32'(bus.req_ready), 32'b0001);
    bus.req_valid = '0;
    tick(4);
    check_eq("mid_no_result", 32'(bus.res_valid), 32'd0);

    // Counter wrap.
    bus.res_ready = 1'b0;
    set_req(3, 1'b1, 0, 100);
    wait_grant(3);
    tick(1);
    check_eq("wrap_res_valid", 32'(bus.res_valid), 32'd1);
    force dut.r_done_count = 16'hFFFF;
    tick(1);
    release dut.r_done_count;
    tick(1);
    check_eq("wrap_forced", 32'(done_count), 32'hFFFF);
    bus.res_ready = 1'b1;
    tick(1);
    check_eq("wrap_zero", 32'(done_count), 32'd0);
    check_eq("wrap_angle", 32'(last_angle), 32'd90);
    wait_idle();
    tick(2);
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
